// File: rtl/nes_bus_pkg.sv
// Shared NES bus definitions.
//   dma_state_e        - OAM DMA state encoding (StAlign only with OAM_DMA_ALIGN_EN)
//   DmaRegAddrDefault  - default CPU address whose write starts an OAM DMA
//   OamDataAddrDefault - default PPU OAM data port address
//   DmaByteCount       - bytes copied per OAM DMA transfer
// Optional feature macro: OAM_DMA_ALIGN_EN (adds the ALIGN state).
package nes_bus_pkg;

  localparam logic [15:0] DmaRegAddrDefault  = 16'h4014;
  localparam logic [15:0] OamDataAddrDefault = 16'h2004;
  localparam int unsigned DmaByteCount       = 256;

  typedef enum logic [2:0] {
    StIdle,
    StHalt,
`ifdef OAM_DMA_ALIGN_EN
    StAlign,
`endif
    StRead,
    StWrite
  } dma_state_e;

endpackage

// File: rtl/oam_dma.sv
// OAM DMA engine with CPU/DMA bus arbitration.
// A CPU write of a page number to DMA_REG_ADDR halts the CPU and copies the 256 bytes
// {page,8'h00}..{page,8'hFF} to OAM_DATA_ADDR, one read cycle plus one write cycle per byte.
// Optional feature macro: OAM_DMA_ALIGN_EN - when defined, a start on an odd cycle inserts one
// idle ALIGN cycle (514 halted cycles instead of 513).
// Ports:
//   clk, b_rst           - clock, asynchronous active-low reset
//   cpu_addr_out/_data_out, ren, wen - CPU bus request
//   bus_rdata            - memory read data (combinational with bus_ren)
//   bus_addr/wdata/ren/wen - arbitrated memory bus
//   rdy                  - CPU ready (0 halts the CPU)
//   busy                 - DMA in progress
module oam_dma
  import nes_bus_pkg::*;
#(
  parameter logic [15:0] DMA_REG_ADDR  = DmaRegAddrDefault,
  parameter logic [15:0] OAM_DATA_ADDR = OamDataAddrDefault
) (
  input  logic        clk,
  input  logic        b_rst,
  input  logic [15:0] cpu_addr_out,
  input  logic [7:0]  cpu_data_out,
  input  logic        ren,
  input  logic        wen,
  input  logic [7:0]  bus_rdata,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_wdata,
  output logic        bus_ren,
  output logic        bus_wen,
  output logic        rdy,
  output logic        busy
);

  localparam logic [7:0] LastIdx = 8'(DmaByteCount - 1);

  dma_state_e state_q, state_d;
  logic [7:0] page_q, page_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] data_q, data_d;

`ifdef OAM_DMA_ALIGN_EN
  // Free-running cycle parity; decides whether the first read needs an extra idle cycle.
  logic parity_q;

  always_ff @(posedge clk or negedge b_rst) begin
    if (!b_rst) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= ~parity_q;
    end
  end
`endif

  always_ff @(posedge clk or negedge b_rst) begin
    if (!b_rst) begin
      state_q <= StIdle;
      page_q  <= 8'h00;
      cnt_q   <= 8'h00;
      data_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      page_q  <= page_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    page_d    = page_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    // CPU owns the bus unless a transfer is in flight.
    bus_addr  = cpu_addr_out;
    bus_wdata = cpu_data_out;
    bus_ren   = ren;
    bus_wen   = wen;
    rdy       = 1'b1;
    busy      = 1'b0;

    if (state_q != StIdle) begin
      bus_addr  = 16'h0000;
      bus_wdata = 8'h00;
      bus_ren   = 1'b0;
      bus_wen   = 1'b0;
      rdy       = 1'b0;
      busy      = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (wen && (cpu_addr_out == DMA_REG_ADDR)) begin
          state_d = StHalt;
          page_d  = cpu_data_out;
          cnt_d   = 8'h00;
        end
      end
      StHalt: begin
`ifdef OAM_DMA_ALIGN_EN
        state_d = parity_q ? StAlign : StRead;
`else
        state_d = StRead;
`endif
      end
`ifdef OAM_DMA_ALIGN_EN
      StAlign: begin
        state_d = StRead;
      end
`endif
      StRead: begin
        bus_addr = {page_q, cnt_q};
        bus_ren  = 1'b1;
        data_d   = bus_rdata;
        state_d  = StWrite;
      end
      StWrite: begin
        bus_addr  = OAM_DATA_ADDR;
        bus_wen   = 1'b1;
        bus_wdata = data_q;
        // cnt wraps within the page; the page never carries.
        cnt_d     = cnt_q + 8'd1;
        state_d   = (cnt_q == LastIdx) ? StIdle : StRead;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

endmodule

// File: tb/tb_oam_dma.sv
// Self-checking bench for oam_dma: idle pass-through vector table, then directed transfers
// (even/odd start, retrigger while busy, page 8'hFF, reset mid-transfer).
module tb_oam_dma;

`ifdef OAM_DMA_ALIGN_EN
  localparam bit AlignEn = 1'b1;
`else
  localparam bit AlignEn = 1'b0;
`endif

  logic        clk;
  logic        b_rst;
  logic [15:0] cpu_addr_out;
  logic [7:0]  cpu_data_out;
  logic        ren;
  logic        wen;
  logic [7:0]  bus_rdata;
  logic [15:0] bus_addr;
  logic [7:0]  bus_wdata;
  logic        bus_ren;
  logic        bus_wen;
  logic        rdy;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int unsigned cyc;

  oam_dma dut (
    .clk          (clk),
    .b_rst        (b_rst),
    .cpu_addr_out (cpu_addr_out),
    .cpu_data_out (cpu_data_out),
    .ren          (ren),
    .wen          (wen),
    .bus_rdata    (bus_rdata),
    .bus_addr     (bus_addr),
    .bus_wdata    (bus_wdata),
    .bus_ren      (bus_ren),
    .bus_wen      (bus_wen),
    .rdy          (rdy),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Rising edges since reset release; its LSB equals the DUT's parity bit.
  always @(posedge clk or negedge b_rst) begin
    if (!b_rst) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  function automatic logic [7:0] mem_f(input logic [15:0] a);
    return a[7:0] ^ {a[3:0], a[15:12]} ^ 8'hA5;
  endfunction

  assign bus_rdata = bus_ren ? mem_f(bus_addr) : 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  data;
    logic        r;
    logic        w;
    logic [15:0] exp_addr;
    logic [7:0]  exp_wdata;
    logic        exp_ren;
    logic        exp_wen;
  } vec_t;

  // Runs one transfer and checks every halted cycle. want_par: parity in HALT (0/1), -1 = any.
  task automatic run_xfer(input logic [7:0] page, input bit retrig, input int want_par,
                          input string tag);
    int low, nrd, nwr, bad, busy_bad, first_rd;
    bit exp_align;
    @(negedge clk);
    if (want_par >= 0 && int'((cyc + 1) & 1) != want_par) @(negedge clk);
    cpu_addr_out = 16'h4014; cpu_data_out = page; wen = 1'b1; ren = 1'b0;
    #1;
    check({tag, "_trig_pass"}, {bus_addr, bus_wdata, 6'd0, bus_ren, bus_wen},
          {16'h4014, page, 6'd0, 1'b0, 1'b1});
    @(negedge clk);
    wen = 1'b0; cpu_addr_out = 16'h0000; cpu_data_out = 8'h00;
    #1;
    exp_align = AlignEn && cyc[0];
    low = 0; nrd = 0; nwr = 0; bad = 0; busy_bad = 0; first_rd = -1;
    while (rdy == 1'b0 && low < 600) begin
      if (busy !== 1'b1) busy_bad++;
      if (low == 0 && (bus_ren || bus_wen)) bad++;
      if (exp_align && low == 1 && (bus_ren || bus_wen)) bad++;
      if (bus_ren && bus_wen) bad++;
      if (bus_ren) begin
        if (first_rd < 0) first_rd = low;
        if (bus_addr !== {page, 8'(nrd)} || nrd != nwr) bad++;
        nrd++;
      end
      if (bus_wen) begin
        if (bus_addr !== 16'h2004 || bus_wdata !== mem_f({page, 8'(nwr)}) || nrd != nwr + 1)
          bad++;
        nwr++;
      end
      if (retrig && low == 40) begin
        cpu_addr_out = 16'h4014; cpu_data_out = 8'h03; wen = 1'b1; ren = 1'b1;
      end
      if (retrig && low == 44) begin
        cpu_addr_out = 16'h0000; cpu_data_out = 8'h00; wen = 1'b0; ren = 1'b0;
      end
      low++;
      @(negedge clk);
      #1;
    end
    check({tag, "_low_cycles"}, low, exp_align ? 514 : 513);
    check({tag, "_reads"}, nrd, 256);
    check({tag, "_writes"}, nwr, 256);
    check({tag, "_seq_errs"}, bad, 0);
    check({tag, "_busy_errs"}, busy_bad, 0);
    check({tag, "_first_rd"}, first_rd, exp_align ? 2 : 1);
    check({tag, "_rdy_after"}, {rdy, busy}, 2'b10);
  endtask

  vec_t vecs[5];

  initial begin
    vecs[0] = '{16'h8000, 8'h00, 1'b1, 1'b0, 16'h8000, 8'h00, 1'b1, 1'b0};
    vecs[1] = '{16'h2000, 8'h55, 1'b0, 1'b1, 16'h2000, 8'h55, 1'b0, 1'b1};
    vecs[2] = '{16'h1234, 8'hAA, 1'b0, 1'b0, 16'h1234, 8'hAA, 1'b0, 1'b0};
    vecs[3] = '{16'h4014, 8'h07, 1'b1, 1'b0, 16'h4014, 8'h07, 1'b1, 1'b0};
    vecs[4] = '{16'h4015, 8'h09, 1'b0, 1'b1, 16'h4015, 8'h09, 1'b0, 1'b1};

    b_rst = 1'b0; cpu_addr_out = 16'hBEEF; cpu_data_out = 8'h3C; ren = 1'b1; wen = 1'b0;
    #12;
    check("reset_out", {bus_addr, bus_wdata, 4'd0, bus_ren, bus_wen, rdy, busy},
          {16'hBEEF, 8'h3C, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0});
    @(negedge clk);
    b_rst = 1'b1; ren = 1'b0;

    // Idle pass-through table; none of these may start a transfer.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      cpu_addr_out = vecs[i].addr; cpu_data_out = vecs[i].data;
      ren = vecs[i].r; wen = vecs[i].w;
      #1;
      check($sformatf("vec%0d_addr", i), bus_addr, vecs[i].exp_addr);
      check($sformatf("vec%0d_wdata", i), bus_wdata, vecs[i].exp_wdata);
      check($sformatf("vec%0d_strb", i), {bus_ren, bus_wen}, {vecs[i].exp_ren, vecs[i].exp_wen});
      check($sformatf("vec%0d_rdy", i), rdy, 1'b1);
      @(negedge clk);
      ren = 1'b0; wen = 1'b0;
      #1;
      check($sformatf("vec%0d_notrig", i), {rdy, busy}, 2'b10);
    end

    run_xfer(8'h02, 1'b0, 0, "even");
    run_xfer(8'h11, 1'b0, 1, "odd");
    run_xfer(8'h07, 1'b1, -1, "retrig");
    run_xfer(8'hFF, 1'b0, -1, "pageff");

    // Reset at byte 10 of a transfer.
    begin
      int n;
      bit hit;
      int wr_after;
      @(negedge clk);
      cpu_addr_out = 16'h4014; cpu_data_out = 8'h05; wen = 1'b1;
      @(negedge clk);
      cpu_addr_out = 16'h1234; cpu_data_out = 8'h00; wen = 1'b0;
      #1;
      hit = 1'b0; n = 0;
      while (!hit && n < 100) begin
        if (bus_ren && bus_addr == 16'h050A) hit = 1'b1;
        else begin
          @(negedge clk);
          #1;
          n++;
        end
      end
      check("rst_byte10_seen", hit, 1'b1);
      b_rst = 1'b0;
      #1;
      check("rst_mid_out", {rdy, busy, bus_ren, bus_wen}, 4'b1000);
      check("rst_mid_pass", bus_addr, 16'h1234);
      @(negedge clk);
      @(negedge clk);
      b_rst = 1'b1;
      wr_after = 0;
      for (int k = 0; k < 30; k++) begin
        @(negedge clk);
        #1;
        if (bus_wen || bus_ren || busy || !rdy) wr_after++;
      end
      check("rst_no_strobes", wr_after, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
